// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter with bounded locking in front of a single-ported data memory.
// Optional macro DMEM_ARB_FIXED_PRIO_EN: port 0 always wins IDLE contests.
module dmem_arbiter #(
    parameter int DEPTH    = 64,
    parameter int MAX_LOCK = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic        lock0,
    input  logic        lock1,
    input  logic [31:0] a0,
    input  logic [31:0] a1,
    input  logic [31:0] wd0,
    input  logic [31:0] wd1,
    output logic        ready0,
    output logic        ready1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        err0,
    output logic        err1,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [7:0] LAST_CNT = 8'(MAX_LOCK - 1);

    state_t      state, stateNext;
    logic        lastGrant, lastGrantNext;
    logic [7:0]  lockCnt, lockCntNext;
    logic        grant0, grant1;
    logic        forcedRelease;
    logic [31:0] selA, selWd;
    logic        selWe, legal;
    logic        rvalid0Q, rvalid1Q, err0Q, err1Q;
    logic [31:0] rdata0Q, rdata1Q;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    logic        forcedPend;
`endif

    // Grant selection and ownership tracking; reset masks every grant.
    always_comb begin
        grant0        = 1'b0;
        grant1        = 1'b0;
        stateNext     = state;
        lockCntNext   = lockCnt;
        forcedRelease = 1'b0;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
                    grant1 = forcedPend;
`else
                    grant1 = ~lastGrant;
`endif
                    grant0 = ~grant1;
                end else begin
                    grant0 = req0;
                    grant1 = req1;
                end
                if (grant0 && lock0) begin
                    stateNext   = OWN0;
                    lockCntNext = 8'd0;
                end else if (grant1 && lock1) begin
                    stateNext   = OWN1;
                    lockCntNext = 8'd0;
                end
            end
            OWN0: begin
                grant0      = req0;
                lockCntNext = lockCnt + 8'd1;
                if (!req0 || !lock0) begin
                    stateNext = IDLE;
                end else if (lockCnt == LAST_CNT) begin
                    stateNext     = IDLE;
                    forcedRelease = 1'b1;
                end
            end
            OWN1: begin
                grant1      = req1;
                lockCntNext = lockCnt + 8'd1;
                if (!req1 || !lock1) begin
                    stateNext = IDLE;
                end else if (lockCnt == LAST_CNT) begin
                    stateNext     = IDLE;
                    forcedRelease = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
        if (reset) begin
            grant0 = 1'b0;
            grant1 = 1'b0;
        end
        lastGrantNext = lastGrant;
        if (grant0) lastGrantNext = 1'b0;
        if (grant1) lastGrantNext = 1'b1;
        // A timed-out owner is marked as last winner so the other port goes next.
        if (forcedRelease) lastGrantNext = (state == OWN1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            lastGrant <= 1'b1;
            lockCnt   <= 8'd0;
        end else begin
            state     <= stateNext;
            lastGrant <= lastGrantNext;
            lockCnt   <= lockCntNext;
        end
    end

`ifdef DMEM_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk) begin
        if (reset) forcedPend <= 1'b0;
        else       forcedPend <= forcedRelease && (state == OWN0);
    end
`endif

    always_comb begin
        selA  = 32'h0;
        selWd = 32'h0;
        selWe = 1'b0;
        if (grant0) begin
            selA  = a0;
            selWd = wd0;
            selWe = we0;
        end else if (grant1) begin
            selA  = a1;
            selWd = wd1;
            selWe = we1;
        end
    end

    assign legal  = (selA[1:0] == 2'b00) && (selA[31:2] < 30'(DEPTH));
    assign mem_we = selWe && legal;
    assign mem_a  = selA;
    assign mem_wd = selWd;
    assign ready0 = grant0;
    assign ready1 = grant1;

    // Responses go out for reads and for any illegal access; illegal ones carry zero data.
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid0Q <= 1'b0;
            rvalid1Q <= 1'b0;
            err0Q    <= 1'b0;
            err1Q    <= 1'b0;
            rdata0Q  <= 32'h0;
            rdata1Q  <= 32'h0;
        end else begin
            rvalid0Q <= grant0 && (!we0 || !legal);
            rvalid1Q <= grant1 && (!we1 || !legal);
            err0Q    <= grant0 && !legal;
            err1Q    <= grant1 && !legal;
            if (grant0 && (!we0 || !legal)) rdata0Q <= legal ? mem_rd : 32'h0;
            if (grant1 && (!we1 || !legal)) rdata1Q <= legal ? mem_rd : 32'h0;
        end
    end

    // Masking during reset drops a response that was already in flight.
    assign rvalid0 = rvalid0Q && !reset;
    assign rvalid1 = rvalid1Q && !reset;
    assign err0    = err0Q && !reset;
    assign err1    = err1Q && !reset;
    assign rdata0  = reset ? 32'h0 : rdata0Q;
    assign rdata1  = reset ? 32'h0 : rdata1Q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed-vector bench for dmem_arbiter with a behavioural 64-word data memory.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [31:0] a0, a1, wd0, wd1;
    logic        ready0, ready1, rvalid0, rvalid1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [0:63];
    logic        memReady = 1'b0;

    dmem_arbiter #(.DEPTH(64), .MAX_LOCK(4)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1),
        .a0(a0), .a1(a1), .wd0(wd0), .wd1(wd1),
        .ready0(ready0), .ready1(ready1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .err0(err0), .err1(err1),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    // Memory preloads word i with 0xA0000000+i on its first edge; out-of-range reads return junk.
    always @(posedge clk) begin
        if (!memReady) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 + 32'(i);
            memReady <= 1'b1;
        end else if (mem_we) begin
            mem[mem_a[7:2]] <= mem_wd;
        end
    end
    assign mem_rd = (mem_a[31:8] == 24'h0 && mem_a[1:0] == 2'b00) ? mem[mem_a[7:2]] : 32'hBAD0_0000;

    task automatic applyStimulus(input logic r0, input logic w0, input logic l0,
                                 input logic [31:0] ad0, input logic [31:0] d0,
                                 input logic r1, input logic w1, input logic l1,
                                 input logic [31:0] ad1, input logic [31:0] d1);
        req0 = r0; we0 = w0; lock0 = l0; a0 = ad0; wd0 = d0;
        req1 = r1; we1 = w1; lock1 = l1; a1 = ad1; wd1 = d1;
    endtask

    task automatic idle;
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    initial begin
        logic exp0;

        // Reset holds everything quiet even with both ports requesting.
        reset = 1'b1;
        applyStimulus(1, 1, 0, 32'h10, 32'h1, 1, 1, 0, 32'h14, 32'h2);
        tick;
        tick;
        checkOutput("rst_ready0", ready0, 0);
        checkOutput("rst_ready1", ready1, 0);
        checkOutput("rst_mem_we", mem_we, 0);
        checkOutput("rst_mem_a", mem_a, 0);
        checkOutput("rst_mem_wd", mem_wd, 0);
        checkOutput("rst_rvalid0", rvalid0, 0);
        checkOutput("rst_rdata0", rdata0, 0);
        reset = 1'b0;
        idle;
        tick;

        // Single write then read on port 0.
        applyStimulus(1, 1, 0, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 32'h0, 32'h0);
        settle;
        checkOutput("wr_ready0", ready0, 1);
        checkOutput("wr_mem_we", mem_we, 1);
        checkOutput("wr_mem_a", mem_a, 32'h10);
        checkOutput("wr_mem_wd", mem_wd, 32'hDEAD_BEEF);
        tick;
        checkOutput("wr_no_rvalid", rvalid0, 0);
        applyStimulus(1, 0, 0, 32'h10, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        settle;
        checkOutput("rd_ready0", ready0, 1);
        checkOutput("rd_mem_we", mem_we, 0);
        tick;
        checkOutput("rd_rvalid0", rvalid0, 1);
        checkOutput("rd_rdata0", rdata0, 32'hDEAD_BEEF);
        checkOutput("rd_err0", err0, 0);

        // Write on port 0 visible to port 1 on the very next cycle.
        applyStimulus(1, 1, 0, 32'h20, 32'h1234_5678, 0, 0, 0, 32'h0, 32'h0);
        tick;
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h20, 32'h0);
        settle;
        checkOutput("xrd_ready1", ready1, 1);
        tick;
        checkOutput("xrd_rvalid1", rvalid1, 1);
        checkOutput("xrd_rdata1", rdata1, 32'h1234_5678);
        idle;
        tick;
        checkOutput("xrd_rvalid1_off", rvalid1, 0);
        checkOutput("xrd_rdata1_hold", rdata1, 32'h1234_5678);

        // Contention from reset: alternating grants.
        reset = 1'b1;
        tick;
        reset = 1'b0;
        tick;
        applyStimulus(1, 0, 0, 32'h10, 32'h0, 1, 0, 0, 32'h14, 32'h0);
        for (int k = 0; k < 4; k++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            exp0 = 1'b1;
`else
            exp0 = (k % 2 == 0);
`endif
            settle;
            checkOutput("cont_ready0", ready0, exp0);
            checkOutput("cont_ready1", ready1, !exp0);
            tick;
            checkOutput("cont_rvalid0", rvalid0, exp0);
            checkOutput("cont_rvalid1", rvalid1, !exp0);
            if (exp0) checkOutput("cont_rdata0", rdata0, 32'hDEAD_BEEF);
            else      checkOutput("cont_rdata1", rdata1, 32'hA000_0005);
        end
        idle;
        tick;

        // Lock: port 0 goes last so port 1 wins, then port 1 holds for three accesses.
        applyStimulus(1, 0, 0, 32'h10, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        tick;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0, 32'h10, 32'h0, 1, 0, (i < 2), 32'h14, 32'h0);
            settle;
            checkOutput("lock_ready0", ready0, 0);
            checkOutput("lock_ready1", ready1, 1);
            tick;
        end
        applyStimulus(1, 0, 0, 32'h10, 32'h0, 1, 0, 0, 32'h14, 32'h0);
        settle;
        checkOutput("lock_after_ready0", ready0, 1);
        checkOutput("lock_after_ready1", ready1, 0);
        tick;
        idle;
        tick;

        // Lock timeout with MAX_LOCK=4: four OWN0 cycles, then port 1.
        applyStimulus(1, 0, 1, 32'h10, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        settle;
        checkOutput("to_enter_ready0", ready0, 1);
        tick;
        applyStimulus(1, 0, 1, 32'h10, 32'h0, 1, 0, 0, 32'h14, 32'h0);
        for (int c = 1; c <= 4; c++) begin
            settle;
            checkOutput("to_own_ready0", ready0, 1);
            checkOutput("to_own_ready1", ready1, 0);
            tick;
        end
        settle;
        checkOutput("to_release_ready1", ready1, 1);
        checkOutput("to_release_ready0", ready0, 0);
        tick;
        checkOutput("to_rvalid1", rvalid1, 1);
        checkOutput("to_rdata1", rdata1, 32'hA000_0005);
        idle;
        tick;

        // Errors: out-of-range and misaligned writes, out-of-range read, last legal word.
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 1, 1, 0, 32'h102, 32'h5555_5555);
        settle;
        checkOutput("err_wr_ready1", ready1, 1);
        checkOutput("err_wr_mem_we", mem_we, 0);
        tick;
        checkOutput("err_wr_rvalid1", rvalid1, 1);
        checkOutput("err_wr_err1", err1, 1);
        checkOutput("err_wr_rdata1", rdata1, 0);
        checkOutput("err_wr_mem0", mem[0], 32'hA000_0000);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 1, 1, 0, 32'h12, 32'h6666_6666);
        settle;
        checkOutput("mis_wr_mem_we", mem_we, 0);
        tick;
        checkOutput("mis_wr_err1", err1, 1);
        checkOutput("mis_wr_mem4", mem[4], 32'hDEAD_BEEF);
        applyStimulus(1, 0, 0, 32'h100, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        tick;
        checkOutput("err_rd_rvalid0", rvalid0, 1);
        checkOutput("err_rd_err0", err0, 1);
        checkOutput("err_rd_rdata0", rdata0, 0);
        applyStimulus(1, 0, 0, 32'hFC, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        tick;
        checkOutput("top_rd_rvalid0", rvalid0, 1);
        checkOutput("top_rd_err0", err0, 0);
        checkOutput("top_rd_rdata0", rdata0, 32'hA000_003F);
        idle;
        tick;

        // Reset right after a read accept drops its response.
        applyStimulus(1, 0, 0, 32'h14, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        tick;
        reset = 1'b1;
        idle;
        settle;
        checkOutput("rst_mid_rvalid0", rvalid0, 0);
        tick;
        checkOutput("rst_mid_rvalid0_edge", rvalid0, 0);
        checkOutput("rst_mid_rdata0", rdata0, 0);
        reset = 1'b0;
        applyStimulus(1, 0, 0, 32'h10, 32'h0, 1, 0, 0, 32'h14, 32'h0);
        settle;
        checkOutput("rst_mid_ready0", ready0, 1);
        checkOutput("rst_mid_ready1", ready1, 0);
        tick;
        checkOutput("rst_mid_rvalid0_after", rvalid0, 1);
        checkOutput("rst_mid_rdata0_after", rdata0, 32'hDEAD_BEEF);
        idle;
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-ported data memory between the core load/store unit (port 0) and the DMA/debug engine (port 1). It issues at most one access per cycle, selects the winner round-robin, and lets a requester lock the memory for a bounded burst. It checks word alignment and range before an access reaches memory, and returns registered read data with a per-port valid pulse. It sits directly between the requesters and the data memory's `we`/`a`/`wd`/`rd` pins.

## Interface
Parameters:
- `DEPTH`, 64: memory depth in 32-bit words. Legal word index is 0..DEPTH-1.
- `MAX_LOCK`, 16: maximum number of consecutive cycles a lock may hold ownership. Range 1..255.

Ports:
- `clk` in 1: the single clock. All state changes on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req0`, `req1` in 1: access request from port 0 / port 1.
- `we0`, `we1` in 1: 1 = write, 0 = read.
- `lock0`, `lock1` in 1: hold ownership after this access.
- `a0`, `a1` in 32: byte address.
- `wd0`, `wd1` in 32: write data.
- `ready0`, `ready1` out 1: request accepted this cycle (combinational).
- `rvalid0`, `rvalid1` out 1: one-cycle response pulse; fires for reads and for erroring writes.
- `rdata0`, `rdata1` out 32: registered read data.
- `err0`, `err1` out 1: the response carrying this flag was misaligned or out of range.
- `mem_we` out 1: write enable to the data memory.
- `mem_a` out 32: address to the data memory.
- `mem_wd` out 32: write data to the data memory.
- `mem_rd` in 32: combinational read data from the data memory.

## Operation
- **States:** IDLE, OWN0, OWN1. Reset enters IDLE and sets `last_grant`=1, so port 0 wins the first contest. The lock counter resets to 0.
- **Arbitration in IDLE:**
  - A single requester wins.
  - If both request, the port != `last_grant` wins.
  - `last_grant` updates on every accept.
- **OWNx:** only port x may be granted; `ready` of the other port is 0.
- **Transitions:**
  - IDLE→OWNx when port x is accepted with `lockx`=1.
  - OWNx→IDLE when port x is accepted with `lockx`=0, or when `reqx`=0 in any OWNx cycle.
  - OWNx→IDLE on forced release: the counter reaches `MAX_LOCK`. The release takes effect after that cycle's access completes, and `last_grant` is set to x so that the other port wins next.
- **Lock counter:** clears on entering OWNx and increments each cycle spent in OWNx.
- **Memory drive:**
  - On accept, `mem_a`/`mem_wd` come from the winner.
  - `mem_we` = winner's `we` AND access legal.
  - With no accept, `mem_we`=0 and `mem_a`=`mem_wd`=0.
- **Legality:** an access is legal when `a[1:0]`==0 and `a[31:2]` < `DEPTH`.
  - An illegal access is still accepted (`ready`=1).
  - Its write is suppressed.
  - Its response is `rvalid`=1, `err`=1, `rdata`=0, for both reads and writes.
- **Legal response:**
  - A legal read captures `mem_rd` into `rdatax`.
  - A legal write produces no `rvalid`.
- **Write-then-read:** a write accepted in cycle N is visible to any read accepted in cycle N+1 or later, from either port.

## Timing
- `ready` is combinational from `req`/`lock`/state in the same cycle. The handshake completes when `req` and `ready` are both 1 at a rising edge.
- **Write latency:** the memory updates on the accepting edge.
- **Read latency:** 1. `rvalidx`/`rdatax`/`errx` are valid in the cycle after accept, for exactly one cycle.
- `rdatax` holds its last value when `rvalidx`=0.
- One accept per cycle total. Back-to-back accepts to the same port give back-to-back `rvalid` pulses.
- **During `reset`=1:**
  - `ready0`/`ready1`=0.
  - `mem_we`=0, `mem_a`=0, `mem_wd`=0.
  - `rvalid`, `err`, `rdata` = 0 after the edge.
- **Reset mid-lock:** returns to IDLE. A response already scheduled for the next cycle is dropped.

## Configuration
- `DMEM_ARB_FIXED_PRIO_EN` defined: in IDLE, port 0 always beats port 1. `last_grant` is ignored, except that a forced lock release still grants port 1 first if it is requesting.
- Undefined (default): round-robin as described above.

## Test plan
- **Single write then read:** port 0 writes 0xDEADBEEF to 0x10, then reads 0x10. Required: `ready0`=1 in both cycles, and `rvalid0`=1 with `rdata0`=0xDEADBEEF one cycle after the read.
- **Contention:** both ports issue continuous reads from reset. Required: grants alternate 0,1,0,1 (default build), or are all port 0 (fixed-priority build).
- **Lock:** port 1 locks with `lock1`=1 for 3 accesses while port 0 requests. Required: `ready0`=0 for those 3 cycles, and port 0 is granted on the 4th cycle.
- **Lock timeout:** `MAX_LOCK`=4, port 0 holds `lock0`=1 indefinitely, port 1 requests. Required: after 4 cycles in OWN0, port 1 is granted on the next cycle.
- **Errors:**
  - Port 1 writes to 0x102: `err1`=1, `rdata1`=0, and memory is unchanged.
  - Port 0 reads 0x100 with `DEPTH`=64: `err0`=1.
- **Reset mid-operation:** assert `reset` in the cycle after a read accept. Required: `rvalid` stays 0, the state is IDLE, and port 0 wins the next contest.
